// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register file geometry and write-arbiter FSM states.
package cpu_defs_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping mod N.
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  logic          found;
  logic [PW-1:0] j;

  // Scan N positions starting at ptr; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port, with owner lock
// for back-to-back multi-register writes and a single registered write slot.
module regfile_wr_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DATA_W  = cpu_defs_pkg::DATA_W,
  parameter int ADDR_W  = cpu_defs_pkg::ADDR_W,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);
  import cpu_defs_pkg::*;

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] data_v;
  logic [N_REQ-1:0]             cand;
  logic [N_REQ-1:0]             grant;
  logic [PW-1:0]                win_idx;
  logic [PW-1:0]                rr_ptr;
  logic [PW-1:0]                owner;
  arb_state_t                   state;
  logic                         out_valid;
  logic                         slot_free;
  logic                         xfer;
  logic                         win_zero;

  assign addr_v = req_addr;
  assign data_v = req_data;

  // While locked only the owner may compete; the picker then trivially selects it.
  assign cand = (state == LOCKED) ? (req_valid & (N_REQ'(1) << owner)) : req_valid;

  rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .valid (cand),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  assign slot_free = ~out_valid | ~wr_stall;
  assign req_ready = slot_free ? grant : '0;
  assign xfer      = |req_ready;
  assign win_zero  = ZERO_RO && (addr_v[win_idx] == ADDR_W'(REG_ZERO));

  assign wr_en = out_valid & ~wr_stall;
  assign busy  = out_valid | (state == LOCKED);

  // Write slot: load on transfer, drain when the register file accepts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (xfer) begin
      wr_addr   <= addr_v[win_idx];
      wr_data   <= data_v[win_idx];
      out_valid <= ~win_zero;
    end else if (!wr_stall) begin
      out_valid <= 1'b0;
    end
  end

  // Arbitration FSM: pointer advance past the winner and lock ownership tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARB;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      if (req_lock[win_idx]) begin
        state <= LOCKED;
        owner <= win_idx;
      end else begin
        state <= ARB;
      end
    end
  end
endmodule
